// File: rtl/div_sequential.sv
// div_sequential: multi-cycle signed divider for the execute stage.
// Restoring shift-subtract on operand magnitudes, then a sign-fix step.
// Truncating semantics: quotient rounds toward zero, remainder takes the
// sign of the dividend. Divide-by-zero and INT_MIN/-1 skip the iterations
// and report an exception one cycle after start.
module div_sequential #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Working registers of the iteration
    logic [WIDTH-1:0] quo_reg;      // holds |A| at start, quotient bits shift in at the LSB
    logic [WIDTH-1:0] rem_reg;      // partial remainder, always < |B|
    logic [WIDTH-1:0] b_mag_reg;    // |B|
    logic [CNT_W-1:0] count_reg;
    logic             sign_a_reg;   // remainder sign
    logic             quo_neg_reg;  // quotient sign
    logic             exc_reg;      // exception path selected at start

    // Operand decode at the start edge
    logic [WIDTH:0]   a_ext;
    logic [WIDTH:0]   b_ext;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             div_ovf;
    logic             exc_start;

    // Magnitudes are formed from sign-extended WIDTH+1 bit values so that
    // |INT_MIN| = 2^(WIDTH-1) is exact; it still fits an unsigned WIDTH-bit word.
    assign a_ext     = {data_operandA[WIDTH-1], data_operandA};
    assign b_ext     = {data_operandB[WIDTH-1], data_operandB};
    assign a_mag     = WIDTH'(a_ext[WIDTH] ? ((WIDTH+1)'(0) - a_ext) : a_ext);
    assign b_mag     = WIDTH'(b_ext[WIDTH] ? ((WIDTH+1)'(0) - b_ext) : b_ext);
    assign div_zero  = (data_operandB == '0);
    assign div_ovf   = (data_operandA == {1'b1, {(WIDTH-1){1'b0}}}) && (data_operandB == '1);
    assign exc_start = div_zero | div_ovf;

    // One restoring step: shift in the next dividend bit, subtract if it fits
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_iter;
    logic [WIDTH-1:0] quo_iter;
    logic             last_iter;

    assign rem_shift = {rem_reg, quo_reg[WIDTH-1]};
    assign rem_ge    = (rem_shift >= {1'b0, b_mag_reg});
    assign rem_iter  = rem_ge ? WIDTH'(rem_shift - {1'b0, b_mag_reg}) : rem_shift[WIDTH-1:0];
    assign quo_iter  = {quo_reg[WIDTH-2:0], rem_ge};
    assign last_iter = (count_reg == CNT_W'(WIDTH - 1));

    // Sign fix applied on the FIX edge
    logic [WIDTH-1:0] quo_fix;
    logic [WIDTH-1:0] rem_fix;

    assign quo_fix = quo_neg_reg ? (WIDTH'(0) - quo_reg) : quo_reg;
    assign rem_fix = sign_a_reg  ? (WIDTH'(0) - rem_reg) : rem_reg;

    assign busy = (state_reg != IDLE);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic: start is only honoured in IDLE
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (ctrl_DIV) state_next = exc_start ? FIX : RUN;
            RUN:     if (last_iter) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands, iterate, then publish the signed result
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            quo_reg        <= '0;
            rem_reg        <= '0;
            b_mag_reg      <= '0;
            count_reg      <= '0;
            sign_a_reg     <= 1'b0;
            quo_neg_reg    <= 1'b0;
            exc_reg        <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (ctrl_DIV) begin
                        quo_reg     <= a_mag;
                        rem_reg     <= '0;
                        b_mag_reg   <= b_mag;
                        count_reg   <= '0;
                        sign_a_reg  <= data_operandA[WIDTH-1];
                        quo_neg_reg <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
                        exc_reg     <= exc_start;
                    end
                end
                RUN: begin
                    rem_reg   <= rem_iter;
                    quo_reg   <= quo_iter;
                    count_reg <= count_reg + CNT_W'(1);
                end
                FIX: begin
                    data_resultRDY <= 1'b1;
                    if (exc_reg) begin
                        data_result    <= '0;
                        data_remainder <= '0;
                        data_exception <= 1'b1;
                    end else begin
                        data_result    <= quo_fix;
                        data_remainder <= rem_fix;
                        data_exception <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_sequential.sv
// Scoreboard bench for div_sequential: stimulus pushes expected responses,
// a monitor pops and compares on every resultRDY pulse.
module tb_div_sequential;

    localparam int W    = 32;
    localparam int NLAT = W + 1;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b1;
    logic          ctrl_div = 1'b0;
    logic [W-1:0]  op_a    = '0;
    logic [W-1:0]  op_b    = '0;
    logic [W-1:0]  res;
    logic [W-1:0]  rem;
    logic          exc;
    logic          rdy;
    logic          busy;

    div_sequential #(.WIDTH(W)) dut (
        .clock          (clk),
        .reset          (rst_n),
        .ctrl_DIV       (ctrl_div),
        .data_operandA  (op_a),
        .data_operandB  (op_b),
        .data_result    (res),
        .data_remainder (rem),
        .data_exception (exc),
        .data_resultRDY (rdy),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    int cycle_cnt = 0;
    always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         e;
        int           end_cycle;
        string        tag;
    } exp_t;

    exp_t sb[$];
    exp_t mon_x;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every resultRDY must match the oldest outstanding expectation
    initial begin
        forever begin
            @(negedge clk);
            if (rdy === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rdy: got rdy=1 at cycle %0d expected no result", cycle_cnt);
                end else begin
                    mon_x = sb.pop_front();
                    chk({mon_x.tag, "_q"},    res, mon_x.q);
                    chk({mon_x.tag, "_r"},    rem, mon_x.r);
                    chk({mon_x.tag, "_exc"},  W'(exc), W'(mon_x.e));
                    chk({mon_x.tag, "_lat"},  W'(cycle_cnt), W'(mon_x.end_cycle));
                    chk({mon_x.tag, "_busy"}, W'(busy), W'(0));
                    $display("txn %s q=%h r=%h exc=%b cycle=%0d", mon_x.tag, res, rem, exc, cycle_cnt);
                end
            end
        end
    end

    // Caller is at a negedge; pulses start for one cycle, then scrambles operands
    task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [W-1:0] q, input logic [W-1:0] r,
                               input logic e, input int lat, input string tag, input bit push);
        exp_t x;
        op_a     = a;
        op_b     = b;
        ctrl_div = 1'b1;
        if (push) begin
            x.q = q; x.r = r; x.e = e; x.end_cycle = cycle_cnt + 1 + lat; x.tag = tag;
            sb.push_back(x);
        end
        @(negedge clk);
        ctrl_div = 1'b0;
        op_a     = $urandom;
        op_b     = $urandom;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL timeout: got %0d pending results expected 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] q, input logic [W-1:0] r,
                           input logic e, input int lat, input string tag);
        @(negedge clk);
        drive_start(a, b, q, r, e, lat, tag, 1'b1);
        wait_done(NLAT + 20);
    endtask

    logic signed [W-1:0] ra, rb;
    int  bc;
    bit  seen;

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #1;
        chk("rst_q", res, '0);
        chk("rst_r", rem, '0);
        chk("rst_exc", W'(exc), W'(0));
        chk("rst_rdy", W'(rdy), W'(0));
        chk("rst_busy", W'(busy), W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic case, busy width
        @(negedge clk);
        drive_start(32'd100, 32'd7, 32'd14, 32'd2, 1'b0, NLAT, "p_p", 1'b1);
        bc = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy === 1'b1) bc++;
            @(negedge clk);
        end
        chk("busy_cycles", W'(bc), W'(33));
        wait_done(5);

        // Sign combinations
        run_one(-32'sd100, 32'sd7,   -32'sd14, -32'sd2, 1'b0, NLAT, "n_p");
        run_one(32'sd100,  -32'sd7,  -32'sd14, 32'sd2,  1'b0, NLAT, "p_n");
        run_one(-32'sd100, -32'sd7,  32'sd14,  -32'sd2, 1'b0, NLAT, "n_n");
        run_one(-32'sd7,   32'sd100, 32'd0,    -32'sd7, 1'b0, NLAT, "small_neg");
        run_one(32'd0,     32'd5,    32'd0,    32'd0,   1'b0, NLAT, "zero_dvd");

        // Exceptions and INT_MIN boundaries
        run_one(32'd5,        32'd0,        32'd0,        32'd0, 1'b1, 1,    "div0");
        run_one(32'h8000_0000, 32'hFFFF_FFFF, 32'd0,      32'd0, 1'b1, 1,    "ovf");
        run_one(32'h8000_0000, 32'd1,       32'h8000_0000, 32'd0, 1'b0, NLAT, "min_1");
        run_one(32'h8000_0000, 32'd2,       32'hC000_0000, 32'd0, 1'b0, NLAT, "min_2");

        // Start while busy is ignored; start in the ready cycle is accepted
        @(negedge clk);
        drive_start(32'd1000, 32'd3, 32'd333, 32'd1, 1'b0, NLAT, "busy_ign", 1'b1);
        repeat (9) @(negedge clk);
        op_a = 32'd9; op_b = 32'd9; ctrl_div = 1'b1;
        @(negedge clk);
        ctrl_div = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < NLAT + 10 && !seen; i++) begin
            if (rdy === 1'b1) seen = 1'b1;
            else @(negedge clk);
        end
        if (seen) begin
            drive_start(32'd9, 32'd3, 32'd3, 32'd0, 1'b0, NLAT, "b2b", 1'b1);
            chk("b2b_hold_q", res, 32'd333);
        end else begin
            checks++;
            errors++;
            $display("FAIL rdy_wait: got no rdy expected rdy for busy_ign");
        end
        wait_done(NLAT + 20);

        // Asynchronous reset aborts an operation
        @(negedge clk);
        drive_start(32'd50, 32'd5, 32'd0, 32'd0, 1'b0, NLAT, "aborted", 1'b0);
        repeat (11) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_q", res, '0);
        chk("abort_r", rem, '0);
        chk("abort_busy", W'(busy), W'(0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("abort_rdy", W'(rdy), W'(0));
        run_one(32'd50, 32'd5, 32'd10, 32'd0, 1'b0, NLAT, "restart");

        // Random sweep against the language's truncating division
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = $urandom >> $urandom_range(0, 31);
            if ($urandom_range(0, 1) == 1) rb = -rb;
            if ($urandom_range(0, 3) == 0) ra = ra >>> $urandom_range(0, 31);
            if (rb == 0) rb = 1;
            if (ra == 32'sh8000_0000 && rb == -32'sd1) rb = 32'sd3;
            run_one(ra, rb, ra / rb, ra % rb, 1'b0, NLAT, "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_sequential.md
Name: div_sequential

Overview:
- Multi-cycle signed 32-bit divider. Complements the multiply path and its overflow detection.
- Sits in the execute stage beside the multiplier. The ALU control issues a one-cycle start pulse.
- Returns quotient, remainder and an exception flag, with a one-cycle ready pulse.
- Uses a restoring shift-subtract iteration on operand magnitudes, then applies a sign-fix step.

Parameters:
- WIDTH, 32, operand/result width in bits. The iteration count equals WIDTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- ctrl_DIV  input  1  start pulse; sampled only when busy=0.
- data_operandA  input  WIDTH  dividend, two's complement; latched on the start edge.
- data_operandB  input  WIDTH  divisor, two's complement; latched on the start edge.
- data_result  output  WIDTH  quotient; held until the next result.
- data_remainder  output  WIDTH  remainder; held until the next result.
- data_exception  output  1  divide-by-zero or INT_MIN/-1 overflow; valid while data_resultRDY=1, held after.
- data_resultRDY  output  1  one-cycle pulse: result, remainder and exception valid.
- busy  output  1  high from the start edge until the result edge.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; all outputs 0; counter, remainder and quotient registers 0.
  - Reset mid-operation aborts the operation immediately. No resultRDY is produced for the aborted operation.
- States: IDLE, RUN, FIX.
- IDLE:
  - ctrl_DIV=1 at edge E0 latches A and B, sign flags, |A| and |B|; sets count=0.
  - B==0 at E0: next state FIX with exception path selected; no iterations run.
  - A==INT_MIN and B==-1 at E0: same as B==0.
  - Otherwise next state RUN; busy=1.
- RUN, one iteration per edge E1..E_WIDTH:
  - Shift {rem, quo} left by 1, bringing in the next |A| MSB.
  - If rem >= |B|: rem -= |B| and set quo LSB=1.
  - Increment count. After count reaches WIDTH, next state FIX.
- FIX, one edge (E_WIDTH+1 normal, E1 exception):
  - Normal path:
    - Quotient sign = signA xor signB; negate quo if the sign is 1.
    - Remainder takes the sign of the dividend (truncating division).
    - Invariant: A = q*B + r, with |r| < |B|.
    - data_exception=0.
  - Exception path: data_result=0, data_remainder=0, data_exception=1.
  - On this edge: data_resultRDY=1 for exactly one cycle, busy=0, next state IDLE.
- Latency, measured from the start edge to the edge that raises resultRDY:
  - Normal: WIDTH+1 cycles (33 at default).
  - Exception: 1 cycle.
- Start handling:
  - ctrl_DIV while busy=1 is ignored; operands are not re-latched.
  - ctrl_DIV in the cycle resultRDY=1 is accepted (state is IDLE) and starts a new operation. Outputs stay at the old result until the new FIX edge.
- Operand changes after E0 have no effect.
- Dividend 0 (B!=0): quotient 0, remainder 0, no exception.
- |A| is computed in WIDTH+1 bits internally so INT_MIN magnitude is exact.
  - INT_MIN / 1 = INT_MIN, remainder 0, no exception.
  - INT_MIN / 2 = -2^30, remainder 0.
- data_resultRDY never asserts twice for one start, and never asserts without a start.

Test Plan:
- A=100, B=7, pulse ctrl_DIV -> resultRDY exactly 33 cycles later; result=14, remainder=2, exception=0; busy high for 33 cycles.
- Sign combinations, one run each:
  - A=-100, B=7 -> -14 r -2.
  - A=100, B=-7 -> -14 r 2.
  - A=-100, B=-7 -> 14 r -2.
  - All with exception=0.
- Exception cases:
  - A=5, B=0 -> resultRDY 1 cycle after start; result=0, remainder=0, exception=1.
  - A=0x80000000, B=0xFFFFFFFF -> same response.
  - Then A=0x80000000, B=1 -> 0x80000000 r 0, exception=0.
- Start A=1000, B=3. Re-pulse ctrl_DIV with A=9, B=9 at cycle 10 -> ignored; result 333 r 1 at cycle 33. Pulse ctrl_DIV with A=9, B=3 in the resultRDY cycle -> 3 r 0 at 33 cycles later.
- Start A=50, B=5. Drive reset=0 asynchronously at cycle 12 for 2 cycles -> all outputs 0 immediately, no resultRDY. Restart A=50, B=5 -> 10 r 0 after 33 cycles.
- Random sweep, 1000 signed pairs with B!=0 and excluding INT_MIN/-1 -> quotient and remainder match the truncating reference model; one resultRDY per start.
